// File: rtl/avalon_mdio_master_if.sv
// Avalon-MM register bus bundle for the MDIO master.
// master drives strobes/address/data; slave returns read data.
interface avalon_mdio_master_if;
  logic        reg_read;
  logic        reg_write;
  logic [1:0]  reg_address;
  logic [31:0] reg_data_in;
  logic        reg_read_valid;
  logic [31:0] reg_data_out;

  modport master (
    output reg_read, reg_write, reg_address, reg_data_in,
    input  reg_read_valid, reg_data_out
  );

  modport slave (
    input  reg_read, reg_write, reg_address, reg_data_in,
    output reg_read_valid, reg_data_out
  );
endinterface

// File: rtl/avalon_mdio_master.sv
// Avalon-MM MDIO master: CTRL/CMD/STATUS/RDATA regs, command FIFO, MDC gen.
// Ports: clk, reset (sync, active-low), bus (Avalon slave), irq, mdc, mdio.
module avalon_mdio_master #(
  parameter int CMD_DEPTH   = 4,
  parameter int DIV_WIDTH   = 16,
  parameter int DIV_DEFAULT = 10
) (
  input  logic                clk,
  input  logic                reset,
  avalon_mdio_master_if.slave bus,
  output logic                irq,
  output logic                mdc,
  inout  wire                 mdio
);
  localparam int LW = $clog2(CMD_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_PRE, S_FRM, S_DAT, S_DONE
  } state_t;

  state_t r_state, w_next;

  logic [DIV_WIDTH-1:0] r_div, r_divl, r_cnt;
  logic                 r_sup, r_ien;
  logic [26:0]          r_mem [CMD_DEPTH];
  logic [LW-1:0]        r_wp, r_rp;
  logic [LW:0]          r_lvl;
  // {op, phyad, regad, wdata}
  logic [26:0]          r_cmd;
  logic [4:0]           r_idx;
  logic                 r_mdc;
  logic                 r_done, r_ovf, r_ta, r_irq;
  logic [15:0]          r_rsh;
  logic [16:0]          r_rdata;
  logic                 r_rv;
  logic [31:0]          r_dout;

  logic                 w_full, w_empty, w_act;
  logic                 w_push, w_acc, w_pop;
  logic                 w_ctrl_wr, w_stat_wr;
  logic                 w_last, w_rise, w_bit_end;
  logic                 w_rd, w_oe, w_out;
  logic [15:0]          w_frm;
  logic [3:0]           w_sel;
  logic [DIV_WIDTH-1:0] w_div_in;
  logic [31:0]          w_rdata;
  logic                 w_unused;

  assign w_full    = (r_lvl == (LW+1)'(CMD_DEPTH));
  assign w_empty   = (r_lvl == '0);
  assign w_act     = (r_state != S_IDLE);
  assign w_push    = bus.reg_write && (bus.reg_address == 2'd1);
  assign w_ctrl_wr = bus.reg_write && (bus.reg_address == 2'd0);
  assign w_stat_wr = bus.reg_write && (bus.reg_address == 2'd2);
  assign w_acc     = w_push && !w_full;
  assign w_pop     = !w_act && !w_empty;
  assign w_last    = (r_cnt == r_divl - DIV_WIDTH'(1));
  assign w_rise    = w_act && !r_mdc && w_last;
  assign w_bit_end = w_act && r_mdc && w_last;
  assign w_rd      = r_cmd[26];
  assign w_frm     = {2'b01, w_rd ? 2'b10 : 2'b01,
                      r_cmd[25:16], 2'b10};
  assign w_sel     = 4'd15 - r_idx[3:0];
  assign w_div_in  = bus.reg_data_in[DIV_WIDTH-1:0];
  assign w_unused  = &{1'b0, bus.reg_data_in[30:26]};

  // DONE is an idle bit: keep the clock low there
  assign mdc  = r_mdc && (r_state != S_DONE);
  assign mdio = w_oe ? w_out : 1'bz;
  assign irq  = r_irq;
  assign bus.reg_read_valid = r_rv;
  assign bus.reg_data_out   = r_dout;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (!w_empty) w_next = r_sup ? S_FRM : S_PRE;
      S_PRE:  if (w_bit_end && r_idx == 5'd31) w_next = S_FRM;
      S_FRM:  if (w_bit_end && r_idx == 5'd15) w_next = S_DAT;
      S_DAT:  if (w_bit_end && r_idx == 5'd15) w_next = S_DONE;
      S_DONE: if (w_bit_end) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // read frames release mdio from the first TA bit on
  always_comb begin
    w_oe  = 1'b0;
    w_out = 1'b0;
    unique case (r_state)
      S_PRE: begin
        w_oe  = 1'b1;
        w_out = 1'b1;
      end
      S_FRM: begin
        w_oe  = !w_rd || (r_idx < 5'd14);
        w_out = w_frm[w_sel];
      end
      S_DAT: begin
        w_oe  = !w_rd;
        w_out = r_cmd[w_sel];
      end
      default: ;
    endcase
  end

  always_comb begin
    w_rdata = '0;
    unique case (bus.reg_address)
      2'd0: w_rdata = {14'd0, r_ien, r_sup, 16'(r_div)};
      2'd1: w_rdata = '0;
      2'd2: w_rdata = {16'd0, 8'(r_lvl), 3'd0, r_ovf,
                       r_done, w_empty, w_full, w_act};
      2'd3: w_rdata = {15'd0, r_rdata};
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (w_acc) r_mem[r_wp] <= {bus.reg_data_in[31],
                               bus.reg_data_in[25:0]};
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_div   <= DIV_WIDTH'(DIV_DEFAULT);
      r_divl  <= DIV_WIDTH'(DIV_DEFAULT);
      r_sup   <= 1'b0;
      r_ien   <= 1'b0;
      r_wp    <= '0;
      r_rp    <= '0;
      r_lvl   <= '0;
      r_cmd   <= '0;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_mdc   <= 1'b0;
      r_done  <= 1'b0;
      r_ovf   <= 1'b0;
      r_ta    <= 1'b0;
      r_rsh   <= '0;
      r_rdata <= '0;
      r_irq   <= 1'b0;
      r_rv    <= 1'b0;
      r_dout  <= '0;
    end else begin
      r_rv <= bus.reg_read;
      if (bus.reg_read) r_dout <= w_rdata;

      if (w_ctrl_wr) begin
        r_div <= (w_div_in == '0) ? DIV_WIDTH'(1) : w_div_in;
        r_sup <= bus.reg_data_in[16];
        r_ien <= bus.reg_data_in[17];
      end

      if (w_stat_wr && bus.reg_data_in[3]) r_done <= 1'b0;
      if (w_stat_wr && bus.reg_data_in[4]) r_ovf  <= 1'b0;
      if (w_push && w_full) r_ovf <= 1'b1;

      if (w_acc) r_wp <= r_wp + LW'(1);
      if (w_pop) begin
        r_rp   <= r_rp + LW'(1);
        r_cmd  <= r_mem[r_rp];
        r_divl <= r_div;
      end
      unique case ({w_acc, w_pop})
        2'b10:   r_lvl <= r_lvl + (LW+1)'(1);
        2'b01:   r_lvl <= r_lvl - (LW+1)'(1);
        default: ;
      endcase

      if (!w_act) begin
        r_cnt <= '0;
        r_mdc <= 1'b0;
        r_idx <= '0;
      end else begin
        if (w_last) begin
          r_cnt <= '0;
          r_mdc <= !r_mdc;
        end else begin
          r_cnt <= r_cnt + DIV_WIDTH'(1);
        end
        if (w_bit_end)
          r_idx <= (w_next != r_state) ? 5'd0 : r_idx + 5'd1;
      end

      // sample on the edge where mdc goes high
      if (w_rise && r_state == S_FRM && r_idx == 5'd15)
        r_ta <= mdio;
      if (w_rise && r_state == S_DAT)
        r_rsh <= {r_rsh[14:0], mdio};

      if (w_bit_end && r_state == S_DONE) begin
        r_done <= 1'b1;
        if (w_rd) r_rdata <= {r_ta, r_rsh};
      end

      r_irq <= r_ien && (r_done || r_ovf);
    end
  end
endmodule
